// File: rtl/mem_req_arb_pkg.sv
// Shared types and helpers for the memory request arbiter and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Lock flag sits this many bits below the word width (i.e. the MSB).
  localparam int unsigned LOCK_BIT_FROM_MSB = 1;

  function automatic int unsigned src_width(input int unsigned n);
    return (n < 2) ? 1 : unsigned'($clog2(n));
  endfunction

  function automatic int unsigned lock_bit_pos(input int unsigned dw);
    return dw - LOCK_BIT_FROM_MSB;
  endfunction

endpackage

// File: rtl/mem_req_arb_if.sv
// Shared memory request channel: valid/ready word with source index.
interface mem_req_arb_if #(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned src_width_p  = 2
);
  logic                    mem_v_o;
  logic [data_width_p-1:0] mem_data_o;
  logic [src_width_p-1:0]  mem_src_o;
  logic                    mem_ready_i;

  modport master (output mem_v_o, mem_data_o, mem_src_o, input mem_ready_i);
  modport slave  (input mem_v_o, mem_data_o, mem_src_o, output mem_ready_i);
endinterface

// File: rtl/mem_req_arb_rr_pick.sv
// Combinational round-robin picker: first eligible request after last_i, with optional force to one index.
module rr_pick #(
  parameter int unsigned num_p       = 4,
  parameter int unsigned idx_width_p = 2
) (
  input  logic [num_p-1:0]       req_i,
  input  logic [idx_width_p-1:0] last_i,
  input  logic                   force_en_i,
  input  logic [idx_width_p-1:0] force_idx_i,
  output logic [num_p-1:0]       gnt_o,
  output logic [idx_width_p-1:0] idx_o,
  output logic                   v_o
);

  logic [num_p-1:0] eligible;

  always_comb begin
    for (int unsigned k = 0; k < num_p; k++) begin
      eligible[k] = req_i[k] & (~force_en_i | (force_idx_i == idx_width_p'(k)));
    end
  end

  always_comb begin
    int unsigned k;
    k     = 0;
    gnt_o = '0;
    idx_o = '0;
    v_o   = 1'b0;
    for (int unsigned i = 1; i <= num_p; i++) begin
      k = int'(last_i) + i;
      if (k >= num_p) k = k - num_p;
      if (!v_o && eligible[k]) begin
        gnt_o[k] = 1'b1;
        idx_o    = idx_width_p'(k);
        v_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arb.sv
// Round-robin drain of per-core request FIFOs into a one-entry output slot.
// Optional requester lock via MEM_REQ_ARB_LOCK_EN.
module mem_req_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned num_req_p    = 4,
  parameter int unsigned data_width_p = 32
) (
  input  logic                              clk_i,
  input  logic                              nreset_i,
  input  logic [num_req_p-1:0]              req_empty_i,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]              req_rd_o,
  mem_req_arb_if.master                     mem,
  output logic                              lock_o
);

  localparam int unsigned src_w = src_width(num_req_p);

  slot_state_t             state_r;
  logic [data_width_p-1:0] data_r;
  logic [src_w-1:0]        src_r;
  logic [src_w-1:0]        last_r;

  logic [num_req_p-1:0]    pick_gnt;
  logic [src_w-1:0]        pick_idx;
  logic                    pick_v;
  logic                    force_en;
  logic                    load;
  logic                    grant;
  logic [data_width_p-1:0] win_data;

  rr_pick #(
    .num_p       (num_req_p),
    .idx_width_p (src_w)
  ) u_pick (
    .req_i       (~req_empty_i),
    .last_i      (last_r),
    .force_en_i  (force_en),
    .force_idx_i (last_r),
    .gnt_o       (pick_gnt),
    .idx_o       (pick_idx),
    .v_o         (pick_v)
  );

  // Ready only feeds the pop path; slot outputs come straight from registers.
  assign load     = (state_r == SLOT_EMPTY) | mem.mem_ready_i;
  assign grant    = load & pick_v & nreset_i;
  assign req_rd_o = grant ? pick_gnt : '0;

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      if (pick_gnt[k]) win_data = win_data | req_data_i[k*data_width_p +: data_width_p];
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_r <= SLOT_EMPTY;
      data_r  <= '0;
      src_r   <= '0;
      last_r  <= src_w'(num_req_p - 1);
    end else if (grant) begin
      state_r <= SLOT_FULL;
      data_r  <= win_data;
      src_r   <= pick_idx;
      last_r  <= pick_idx;
    end else if (mem.mem_ready_i) begin
      state_r <= SLOT_EMPTY;
    end
  end

  assign mem.mem_v_o    = (state_r == SLOT_FULL);
  assign mem.mem_data_o = data_r;
  assign mem.mem_src_o  = src_r;

`ifdef MEM_REQ_ARB_LOCK_EN
  localparam int unsigned lock_bit = lock_bit_pos(data_width_p);
  logic lock_r;

  // While locked the picker only sees last_r, so any grant comes from the lock owner.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i)  lock_r <= 1'b0;
    else if (grant) lock_r <= win_data[lock_bit];
  end

  assign force_en = lock_r;
  assign lock_o   = lock_r;
`else
  assign force_en = 1'b0;
  assign lock_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arb.sv
// Bench for mem_req_arb: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_mem_req_arb;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic [NR-1:0]     req_empty = '1;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_rd;
  logic              lock;
  logic              rdy = 1'b0;

  mem_req_arb_if #(.data_width_p(DW), .src_width_p(SW)) mem_bus ();
  assign mem_bus.mem_ready_i = rdy;

  mem_req_arb #(.num_req_p(NR), .data_width_p(DW)) dut (
    .clk_i       (clk),
    .nreset_i    (nreset),
    .req_empty_i (req_empty),
    .req_data_i  (req_data),
    .req_rd_o    (req_rd),
    .mem         (mem_bus),
    .lock_o      (lock)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO contents plus the arbiter's observable state.
  logic [DW-1:0] q [NR][$];
  bit            m_v;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_src;
  int            m_last;
  bit            m_lock;

  task automatic drive_fifos();
    for (int k = 0; k < NR; k++) begin
      req_empty[k]         = (q[k].size() == 0);
      req_data[k*DW +: DW] = (q[k].size() != 0) ? q[k][0] : '0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) q[k].delete();
    m_v = 0; m_data = '0; m_src = '0; m_last = NR - 1; m_lock = 0;
    drive_fifos();
  endtask

  function automatic void model_pick(output bit g, output int w);
    g = 0; w = 0;
    if (m_v && !rdy) return;
    for (int i = 1; i <= NR; i++) begin
      int k;
      k = (m_last + i) % NR;
      if (!g && !(m_lock && k != m_last) && q[k].size() != 0) begin
        g = 1; w = k;
      end
    end
  endfunction

  function automatic logic [NR-1:0] model_rd();
    bit g; int w;
    logic [NR-1:0] e;
    e = '0;
    model_pick(g, w);
    if (g) e[w] = 1'b1;
    return e;
  endfunction

  task automatic tick();
    bit g; int w;
    model_pick(g, w);
    @(posedge clk); #1;
    if (g) begin
      m_data = q[w].pop_front();
      m_v    = 1;
      m_src  = SW'(w);
      m_last = w;
`ifdef MEM_REQ_ARB_LOCK_EN
      m_lock = m_data[DW-1];
`endif
    end else if (m_v && rdy) begin
      m_v = 0;
    end
    drive_fifos();
    #1;
  endtask

  task automatic do_reset();
    #3 nreset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 nreset = 1'b1;
    #1;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    rdy = 1'b1;
    while ((m_v || q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0) && cyc < 300) begin
      if (m_lock && q[m_last].size() == 0) begin
        q[m_last].push_back('0);
        drive_fifos(); #1;
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc >= 300 || mem_bus.mem_v_o !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_timeout: cycles %0d mem_v_o %b, required idle within 300", cyc, mem_bus.mem_v_o);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    model_reset();
    rdy = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    n_cmp++; if (mem_bus.mem_v_o !== 1'b0) begin n_bad++; $display("FAIL reset_v: got %b want 0", mem_bus.mem_v_o); end
    n_cmp++; if (mem_bus.mem_data_o !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", mem_bus.mem_data_o); end
    n_cmp++; if (mem_bus.mem_src_o !== '0) begin n_bad++; $display("FAIL reset_src: got %0d want 0", mem_bus.mem_src_o); end
    n_cmp++; if (req_rd !== '0) begin n_bad++; $display("FAIL reset_rd: got %b want 0000", req_rd); end
    n_cmp++; if (lock !== 1'b0) begin n_bad++; $display("FAIL reset_lock: got %b want 0", lock); end
    nreset = 1'b1;
    #1;
  endtask

  task automatic test_rr_order();
    logic [DW-1:0] base [NR];
    base = '{32'hA0, 32'hB0, 32'hC0, 32'hD0};
    for (int k = 0; k < NR; k++) q[k].push_back(base[k]);
    rdy = 1'b1;
    drive_fifos(); #1;
    for (int i = 0; i <= NR; i++) begin
      logic [NR-1:0] e;
      e = (i < NR) ? NR'(1 << i) : '0;
      n_cmp++; if (req_rd !== e) begin n_bad++; $display("FAIL rr_rd[%0d]: got %b want %b", i, req_rd, e); end
      if (i > 0) begin
        n_cmp++; if (mem_bus.mem_v_o !== 1'b1 || mem_bus.mem_data_o !== base[i-1] || mem_bus.mem_src_o !== SW'(i-1)) begin
          n_bad++;
          $display("FAIL rr_out[%0d]: got v=%b data=%h src=%0d want v=1 data=%h src=%0d",
                   i, mem_bus.mem_v_o, mem_bus.mem_data_o, mem_bus.mem_src_o, base[i-1], i-1);
        end
      end
      tick();
    end
    n_cmp++; if (mem_bus.mem_v_o !== 1'b0) begin n_bad++; $display("FAIL rr_empty: got v=%b want 0", mem_bus.mem_v_o); end
  endtask

  task automatic test_single_req();
    rdy = 1'b1;
    for (int j = 0; j < 3; j++) q[2].push_back(DW'(32'h21 + j));
    drive_fifos(); #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (req_rd !== 4'b0100) begin n_bad++; $display("FAIL single_rd[%0d]: got %b want 0100", i, req_rd); end
      tick();
      n_cmp++; if (mem_bus.mem_v_o !== 1'b1 || mem_bus.mem_data_o !== DW'(32'h21 + i) || mem_bus.mem_src_o !== 2'd2) begin
        n_bad++;
        $display("FAIL single_out[%0d]: got v=%b data=%h src=%0d want v=1 data=%h src=2",
                 i, mem_bus.mem_v_o, mem_bus.mem_data_o, mem_bus.mem_src_o, 32'h21 + i);
      end
    end
    q[1].push_back(32'h11);
    q[2].push_back(32'h24);
    drive_fifos(); #1;
    n_cmp++; if (req_rd !== 4'b0010) begin n_bad++; $display("FAIL single_next1: got %b want 0010", req_rd); end
    tick();
    n_cmp++; if (req_rd !== 4'b0100) begin n_bad++; $display("FAIL single_next2: got %b want 0100", req_rd); end
    drain();
  endtask

  task automatic test_backpressure();
    rdy = 1'b1;
    q[1].push_back(32'h55);
    drive_fifos(); #1;
    tick();
    rdy = 1'b0;
    for (int k = 0; k < NR; k++) q[k].push_back(DW'(32'h60 + k));
    drive_fifos(); #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (req_rd !== '0) begin n_bad++; $display("FAIL stall_rd[%0d]: got %b want 0000", i, req_rd); end
      n_cmp++; if (mem_bus.mem_v_o !== 1'b1 || mem_bus.mem_data_o !== 32'h55 || mem_bus.mem_src_o !== 2'd1) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got v=%b data=%h src=%0d want v=1 data=55 src=1",
                 i, mem_bus.mem_v_o, mem_bus.mem_data_o, mem_bus.mem_src_o);
      end
      tick();
    end
    rdy = 1'b1; #1;
    n_cmp++; if (req_rd !== 4'b0100) begin n_bad++; $display("FAIL release_rd: got %b want 0100", req_rd); end
    tick();
    n_cmp++; if (mem_bus.mem_data_o !== 32'h62 || mem_bus.mem_src_o !== 2'd2) begin
      n_bad++; $display("FAIL release_out: got data=%h src=%0d want data=62 src=2", mem_bus.mem_data_o, mem_bus.mem_src_o);
    end
    drain();
  endtask

  task automatic test_async_reset();
    rdy = 1'b0;
    q[3].push_back(32'h77);
    drive_fifos(); #1;
    tick();
    n_cmp++; if (mem_bus.mem_v_o !== 1'b1) begin n_bad++; $display("FAIL areset_pre: got v=%b want 1", mem_bus.mem_v_o); end
    #2 nreset = 1'b0;
    #1;
    n_cmp++; if (mem_bus.mem_v_o !== 1'b0 || mem_bus.mem_data_o !== '0) begin
      n_bad++; $display("FAIL areset_async: got v=%b data=%h want v=0 data=0", mem_bus.mem_v_o, mem_bus.mem_data_o);
    end
    model_reset();
    @(posedge clk); #3 nreset = 1'b1;
    for (int k = 0; k < NR; k++) q[k].push_back(DW'(32'h90 + k));
    rdy = 1'b1;
    drive_fifos(); #1;
    n_cmp++; if (req_rd !== 4'b0001) begin n_bad++; $display("FAIL areset_first: got %b want 0001", req_rd); end
    drain();
  endtask

  task automatic test_idle();
    int saved;
    logic [NR-1:0] e;
    saved = m_last;
    for (int i = 0; i < 8; i++) begin
      rdy = 1'($urandom_range(0, 1)); #1;
      n_cmp++; if (mem_bus.mem_v_o !== 1'b0 || req_rd !== '0) begin
        n_bad++; $display("FAIL idle[%0d]: got v=%b rd=%b want v=0 rd=0000", i, mem_bus.mem_v_o, req_rd);
      end
      tick();
    end
    for (int k = 0; k < NR; k++) q[k].push_back(DW'(32'hE0 + k));
    rdy = 1'b1;
    drive_fifos(); #1;
    e = '0; e[(saved + 1) % NR] = 1'b1;
    n_cmp++; if (req_rd !== e) begin n_bad++; $display("FAIL idle_prio: got %b want %b", req_rd, e); end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [NR-1:0] e;
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 9) < 3) begin
          logic [DW-1:0] d;
          d = $urandom;
`ifdef MEM_REQ_ARB_LOCK_EN
          d[DW-1] = ($urandom_range(0, 15) == 0);
`endif
          q[k].push_back(d);
        end
      end
      rdy = ($urandom_range(0, 9) < 7);
      drive_fifos(); #1;
      e = model_rd();
      n_cmp++; if (req_rd !== e) begin n_bad++; $display("FAIL rand_rd[%0d]: got %b want %b", c, req_rd, e); end
      n_cmp++; if (mem_bus.mem_v_o !== m_v) begin n_bad++; $display("FAIL rand_v[%0d]: got %b want %b", c, mem_bus.mem_v_o, m_v); end
      if (m_v) begin
        n_cmp++; if (mem_bus.mem_data_o !== m_data || mem_bus.mem_src_o !== m_src) begin
          n_bad++; $display("FAIL rand_out[%0d]: got data=%h src=%0d want data=%h src=%0d",
                            c, mem_bus.mem_data_o, mem_bus.mem_src_o, m_data, m_src);
        end
      end
      n_cmp++; if (lock !== m_lock) begin n_bad++; $display("FAIL rand_lock[%0d]: got %b want %b", c, lock, m_lock); end
      tick();
    end
    drain();
  endtask

`ifdef MEM_REQ_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    rdy = 1'b1;
    q[1].push_back(32'h8000_0001);
    drive_fifos(); #1;
    n_cmp++; if (req_rd !== 4'b0010) begin n_bad++; $display("FAIL lock_first: got %b want 0010", req_rd); end
    tick();
    q[0].push_back(32'h10); q[2].push_back(32'h12); q[3].push_back(32'h13);
    drive_fifos(); #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (req_rd !== '0 || lock !== 1'b1) begin
        n_bad++; $display("FAIL lock_hold[%0d]: got rd=%b lock=%b want rd=0000 lock=1", i, req_rd, lock);
      end
      tick();
    end
    q[1].push_back(32'h0000_0002);
    drive_fifos(); #1;
    n_cmp++; if (req_rd !== 4'b0010) begin n_bad++; $display("FAIL lock_second: got %b want 0010", req_rd); end
    tick();
    n_cmp++; if (lock !== 1'b0 || mem_bus.mem_data_o !== 32'h2) begin
      n_bad++; $display("FAIL lock_clear: got lock=%b data=%h want lock=0 data=2", lock, mem_bus.mem_data_o);
    end
    n_cmp++; if (req_rd !== 4'b0100) begin n_bad++; $display("FAIL lock_next: got %b want 0100", req_rd); end
    drain();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_order();
    test_single_req();
    test_backpressure();
    test_async_reset();
    test_idle();
    test_random();
`ifdef MEM_REQ_ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_req_arb.md
Name: mem_req_arb

Overview:
- Round-robin arbiter that drains num_req_p per-core request FIFOs onto a single shared memory request channel.
- Sits between the per-core request fifo instances and the memory controller.
- Pops the FIFO head of the winning requester directly through its rd_i.
- Holds the popped word in a one-entry output register and presents it with valid/ready and a source index.

Parameters:
- num_req_p, 4, number of requesters (power of two not required, >=2).
- data_width_p, 32, width of a request word.

Ports:
- clk_i  input  1  clock.
- nreset_i  input  1  reset, asynchronous, active-low.
- req_empty_i  input  num_req_p  per-requester FIFO empty_o.
- req_data_i  input  num_req_p*data_width_p  per-requester FIFO rdata_o; requester k occupies bits [k*data_width_p +: data_width_p].
- req_rd_o  output  num_req_p  per-requester FIFO rd_i (pop); at most one bit set.
- mem_v_o  output  1  output slot holds a valid request.
- mem_data_o  output  data_width_p  request word.
- mem_src_o  output  $clog2(num_req_p)  index of the requester that produced mem_data_o.
- mem_ready_i  input  1  downstream accepts the word when mem_v_o & mem_ready_i.
- lock_o  output  1  arbitration locked to one requester (always 0 without the optional feature).

Behaviour:
- Reset (asynchronous, on nreset_i low):
  - mem_v_o=0, mem_data_o=0, mem_src_o=0, lock_o=0, req_rd_o=0.
  - Last-grant pointer last_r = num_req_p-1, so requester 0 wins first.
  - Reset mid-transfer discards the slot contents; the upstream FIFOs reset in the same domain.
- Slot states: EMPTY (mem_v_o=0) and FULL (mem_v_o=1).
- load = EMPTY | (FULL & mem_ready_i).
- Grant, combinational:
  - Active only when load=1 and at least one requester has req_empty_i[k]=0.
  - Winner is the first non-empty requester searching last_r+1, last_r+2, ..., wrapping modulo num_req_p.
  - req_rd_o[winner]=1 in that same cycle.
  - Never assert req_rd_o for an empty requester.
- Next edge after a grant: slot <= req_data_i[winner], mem_src_o <= winner, mem_v_o <= 1, last_r <= winner.
- Next edge without a grant:
  - FULL & mem_ready_i -> EMPTY.
  - FULL & ~mem_ready_i -> unchanged. mem_data_o and mem_src_o must stay stable while mem_v_o=1 and mem_ready_i=0.
- Transitions:
  - EMPTY->FULL on grant.
  - FULL->FULL on grant with mem_ready_i=1 (back-to-back).
  - FULL->EMPTY on mem_ready_i with no grant.
- Latency: FIFO head to mem_v_o is 1 cycle. Sustained throughput is 1 word/cycle while mem_ready_i=1.
- last_r changes only on a grant. Idle cycles do not rotate priority.
- mem_ready_i may be high while mem_v_o=0; this has no effect beyond load=1.
- No combinational path from mem_ready_i to mem_v_o or mem_data_o. A path from mem_ready_i to req_rd_o is permitted.

Optional Feature:
- Macro: MEM_REQ_ARB_LOCK_EN.
- Defined:
  - Bit data_width_p-1 of each granted word is a lock flag and is still forwarded unchanged.
  - Granting a word with lock=1 sets lock_r. lock_o=lock_r.
  - While lock_r=1 only requester last_r may be granted. Other requesters are held off even if last_r is empty; the arbiter simply waits.
  - Granting a word with lock=0 from the locked requester clears lock_r.
  - Reset clears lock_r.
- Undefined: bit data_width_p-1 is ordinary data; pure round-robin; lock_o tied 0.

Decomposition:
- Shared package mem_arb_pkg:
  - src index width function/localparam ($clog2(num_req_p)).
  - Typedef for the slot state enum {SLOT_EMPTY, SLOT_FULL}.
  - LOCK_BIT position constant.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: request vector, last-grant index, optional force/mask.
  - Outputs: one-hot grant and encoded index.
  - Reused by future response routers.

Test Plan:
- Reset then all four FIFOs loaded with 0xA0/0xB0/0xC0/0xD0, mem_ready_i=1:
  - req_rd_o sequence 0001,0010,0100,1000 on consecutive cycles.
  - mem_data_o A0,B0,C0,D0 with mem_src_o 0,1,2,3, each one cycle after its pop.
- Only requester 2 non-empty with 3 words, mem_ready_i=1:
  - Three consecutive grants to 2, mem_v_o high for 3 cycles, last_r=2 afterwards.
  - Next word on requester 1 wins before requester 2's refill.
- Slot FULL with 0x55 from src 1, mem_ready_i=0 for 5 cycles, all FIFOs non-empty:
  - req_rd_o=0 throughout, mem_data_o stable at 0x55.
  - On mem_ready_i=1, requester 2 is popped in that same cycle and its word appears next cycle.
- nreset_i asserted low mid-cycle while mem_v_o=1:
  - mem_v_o drops immediately without waiting for a clock edge.
  - After release, first grant goes to requester 0.
- All FIFOs empty, mem_ready_i toggling: mem_v_o stays 0, req_rd_o stays 0, last_r unchanged.
- With MEM_REQ_ARB_LOCK_EN, requester 1 sends 0x8000_0001 then, 3 cycles later, 0x0000_0002; requesters 0, 2 and 3 are non-empty:
  - Only requester 1 is granted; lock_o=1 between the two words.
  - lock_o=0 after the second word; the next grant goes to requester 2.
